jtpopeye_busarb: RTL
====================

# jtpopeye_busarb

Bus responder for the Popeye object-RAM DMA: it answers the DMA engine's `busrq_n` request by halting the main CPU at a machine-cycle boundary and driving `busak_n`. While the bus is granted, it serves 8-bit reads from the 1 kB object RAM at the DMA's address. It sits between the main CPU, the object RAM and the DMA engine, and replaces the Z80's internal BUSRQ/BUSAK logic and the object-RAM address multiplexer.

## Interface
Parameters:
- `RELEASE_CYC`, default 1: number of `cen` cycles the CPU stays halted after `busak_n` deasserts (bus turnaround); valid range 1–3.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `cen`  in  1  clock enable; all state advances only when `cen=1`
- `busrq_n`  in  1  bus request from the DMA, active low
- `busak_n`  out  1  bus acknowledge to the DMA, active low
- `AD_DMA`  in  10  object-RAM byte address from the DMA
- `dma_cs`  in  1  DMA read strobe, honoured only while granted
- `DD_DMA`  out  8  registered object-RAM read data to the DMA
- `cpu_mreq_n`  in  1  CPU memory-cycle-in-progress, active low
- `cpu_iorq_n`  in  1  CPU I/O-cycle-in-progress, active low
- `cpu_addr`  in  10  CPU object-RAM address
- `cpu_dout`  in  8  CPU write data
- `cpu_wr_n`  in  1  CPU write strobe, active low
- `obj_cs`  in  1  CPU object-RAM chip select
- `obj_dout`  out  8  registered object-RAM read data to the CPU
- `cpu_cen`  out  1  gated CPU clock enable: equals `cen` when the CPU is not halted, else 0

## Operation
- Storage: 1024×8 RAM, single port, with the address muxed by state. Contents are not reset.
- FSM states: IDLE, WAIT, GRANT, RELEASE. All transitions occur on `clk` edges with `cen=1`.
- IDLE:
  - `busrq_n=0` → WAIT.
- WAIT:
  - `busrq_n=1` → IDLE; no grant is issued and `busak_n` stays 1.
  - Else, `cpu_mreq_n=1` and `cpu_iorq_n=1` (cycle boundary) → GRANT.
  - Else, stay in WAIT.
- GRANT:
  - `busak_n=0`, and the CPU is halted (`cpu_cen=0`).
  - `busrq_n=1` → RELEASE.
- RELEASE:
  - `busak_n=1` and the CPU stays halted.
  - A down-counter loaded with `RELEASE_CYC` reaches 0 → IDLE.
  - `busrq_n=0` here → go to IDLE first, then WAIT on the next `cen`. There is no direct re-grant.
- RAM access:
  - In IDLE and WAIT, the RAM address is `cpu_addr`.
  - `obj_cs & ~cpu_wr_n` writes `cpu_dout`.
  - `obj_cs & cpu_wr_n` loads `obj_dout`.
  - In GRANT, the RAM address is `AD_DMA`. `dma_cs=1` loads `DD_DMA` with `ram[AD_DMA]`.
  - CPU writes are ignored in GRANT and RELEASE.
  - `dma_cs` is ignored outside GRANT.
- `DD_DMA` and `obj_dout` hold their values when not loaded.

## Timing
- Reset values: state=IDLE, `busak_n=1`, `DD_DMA=8'h00`, `obj_dout=8'h00`, halt=0 (so `cpu_cen=cen`), release counter=0.
- Reset mid-GRANT: `busak_n` returns to 1 and the CPU is released immediately (asynchronous).
- `busak_n` and halt are registered, and both change on the same `cen` edge as the state change.
  - Minimum request-to-grant latency: 2 `cen` cycles (IDLE→WAIT, WAIT→GRANT), with the CPU idle.
  - No maximum: WAIT persists while the CPU holds `cpu_mreq_n` or `cpu_iorq_n` low.
- `cpu_cen` is combinational: `cen & ~halt`. It is glitch-free because halt changes only on clock edges.
- DMA read latency: `dma_cs` and `AD_DMA` sampled at `cen` edge N → `DD_DMA` valid after edge N, held until the next load. The first `dma_cs` is accepted on the first `cen` with `busak_n=0`.
- Release timing:
  - `busrq_n` rises → `busak_n=1` one `cen` later.
  - `cpu_cen` resumes `RELEASE_CYC` `cen` cycles after that.
- Simultaneous events on the WAIT→GRANT edge: a CPU write is still performed, because the state was still WAIT.

## Test plan
- Reset: after `rst` pulse → `busak_n=1`, `DD_DMA=0`, `cpu_cen` tracks `cen` on 10 consecutive enables.
- Basic grant with the CPU idle (`cpu_mreq_n=1`):
  - Stimulus: `busrq_n` falls at `cen` edge 0.
  - Response: `busak_n=0` and `cpu_cen=0` after edge 2.
  - Then: `busrq_n` rises → `busak_n=1` one `cen` later; `cpu_cen` resumes `RELEASE_CYC`=1 `cen` later.
- CPU busy:
  - Stimulus: hold `cpu_mreq_n=0` for 7 `cen` cycles after the request.
  - Response: `busak_n` stays 1 throughout; grant occurs 1 `cen` after `cpu_mreq_n` rises.
- Data path, expected values:
  - CPU writes `ram[10'h155]=8'hA5` and `ram[10'h3FF]=8'h3C` in IDLE.
  - After the grant: `dma_cs` with `AD_DMA=10'h155` → `DD_DMA=8'hA5` next `cen`; `AD_DMA=10'h3FF` → `DD_DMA=8'h3C`.
- Data path, blocked accesses:
  - A CPU write of 8'hFF to 10'h155 during GRANT leaves the value 8'hA5.
  - `dma_cs` in IDLE leaves `DD_DMA` unchanged.
- Aborted request: `busrq_n` pulses low for 1 `cen` while `cpu_iorq_n=0` → FSM returns to IDLE, `busak_n` never drops, `cpu_cen` never gated.

Source files
------------

// File: rtl/jtpopeye_busarb.sv
`default_nettype none
// ============================================================================
//  Module   : jtpopeye_busarb
//  Purpose  : Bus responder for the Popeye object-RAM DMA. Halts the main CPU
//             at a machine-cycle boundary, acknowledges the DMA request and
//             serves DMA reads from the 1 kB object RAM while granted.
//  Revision : 1.0 - initial release
// ============================================================================
module jtpopeye_busarb #(
  parameter int RELEASE_CYC = 1   // halted cen cycles after busak_n rises (1..3)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  // DMA side
  input  logic       busrq_n,
  output logic       busak_n,
  input  logic [9:0] AD_DMA,
  input  logic       dma_cs,
  output logic [7:0] DD_DMA,
  // CPU side
  input  logic       cpu_mreq_n,
  input  logic       cpu_iorq_n,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  input  logic       cpu_wr_n,
  input  logic       obj_cs,
  output logic [7:0] obj_dout,
  output logic       cpu_cen
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_GRANT   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [1:0] REL_LOAD   = 2'(RELEASE_CYC);

  logic [1:0] state;
  logic       halt;
  logic [1:0] rel_cnt;

  logic [7:0] ram [0:1023];
  logic [9:0] ram_addr;
  logic [7:0] ram_rd;
  logic       cpu_owns;
  logic       ram_wr;
  logic       cpu_at_boundary;

  // The CPU owns the RAM only before the bus has been handed over; during
  // GRANT and the turnaround that follows, its accesses are dropped.
  assign cpu_owns        = (state == ST_IDLE) || (state == ST_WAIT);
  assign ram_addr        = (state == ST_GRANT) ? AD_DMA : cpu_addr;
  assign ram_wr          = cen && cpu_owns && obj_cs && !cpu_wr_n;
  assign ram_rd          = ram[ram_addr];
  assign cpu_at_boundary = cpu_mreq_n && cpu_iorq_n;

  // halt is a flop, so gating cen with it cannot glitch
  assign cpu_cen = cen & ~halt;

  // Object RAM write port (contents are deliberately not reset)
  always_ff @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= cpu_dout;
  end

  // Registered read data for the CPU and the DMA; each holds until reloaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obj_dout <= 8'h00;
      DD_DMA   <= 8'h00;
    end else if (cen) begin
      if (cpu_owns && obj_cs && cpu_wr_n) obj_dout <= ram_rd;
      if ((state == ST_GRANT) && dma_cs)  DD_DMA   <= ram_rd;
    end
  end

  // Request/grant/release sequencing; busak_n and halt move with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      busak_n <= 1'b1;
      halt    <= 1'b0;
      rel_cnt <= 2'd0;
    end else if (cen) begin
      case (state)
        ST_IDLE: begin
          if (!busrq_n) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (busrq_n) begin
            state <= ST_IDLE;             // request withdrawn before grant
          end else if (cpu_at_boundary) begin
            state   <= ST_GRANT;
            busak_n <= 1'b0;
            halt    <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (busrq_n) begin
            state   <= ST_RELEASE;
            busak_n <= 1'b1;
            rel_cnt <= REL_LOAD;
          end
        end
        ST_RELEASE: begin
          // A new request ends the turnaround early; it is re-arbitrated
          // from IDLE so the CPU always gets a chance to reach a boundary.
          if (!busrq_n || (rel_cnt <= 2'd1)) begin
            state   <= ST_IDLE;
            halt    <= 1'b0;
            rel_cnt <= 2'd0;
          end else begin
            rel_cnt <= rel_cnt - 2'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          busak_n <= 1'b1;
          halt    <= 1'b0;
          rel_cnt <= 2'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
